// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for an N-digit common-anode 7-segment display.
// Double-buffered hex value, per-digit enable, leading-zero blanking, guard gap.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int GAP_CYC    = 2000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_en,
    output logic                    ack,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    typedef enum logic {PH_GAP, PH_ON} phase_t;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    phase_t                  phase;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] pend_data, act_data;
    logic [NUM_DIGITS-1:0]   pend_en, act_en;
    logic                    pend_lz, act_lz, pend_valid;

    logic [IW-1:0]           hi;
    logic                    lit;
    logic [3:0]              nib;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 7'b0000001;
            4'h1: seg_code = 7'b1001111;
            4'h2: seg_code = 7'b0010010;
            4'h3: seg_code = 7'b0000110;
            4'h4: seg_code = 7'b1001100;
            4'h5: seg_code = 7'b0100100;
            4'h6: seg_code = 7'b0100000;
            4'h7: seg_code = 7'b0001111;
            4'h8: seg_code = 7'b0000000;
            4'h9: seg_code = 7'b0000100;
            4'hA: seg_code = 7'b0001000;
            4'hB: seg_code = 7'b1100000;
            4'hC: seg_code = 7'b0110001;
            4'hD: seg_code = 7'b1000010;
            4'hE: seg_code = 7'b0110000;
            default: seg_code = 7'b0111000;
        endcase
    endfunction

    assign frame_end = (cnt == CNT_MAX) && (idx == IDX_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // load/ack: load is a one-cycle strobe with no ready; it always lands in the
    // pending buffer (last write wins). ack pulses for one cycle after the frame
    // boundary that moved a valid pending value into the active buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data  <= '0;
            pend_en    <= '0;
            pend_lz    <= 1'b0;
            pend_valid <= 1'b0;
            act_data   <= '0;
            act_en     <= '1;
            act_lz     <= 1'b0;
            ack        <= 1'b0;
        end else begin
            if (frame_end && pend_valid) begin
                act_data <= pend_data;
                act_en   <= pend_en;
                act_lz   <= pend_lz;
            end
            if (load) begin
                pend_data  <= data;
                pend_en    <= digit_en;
                pend_lz    <= lz_en;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
            ack <= frame_end && pend_valid;
        end
    end

    // hi = highest enabled digit holding a nonzero nibble; stays 0 when none,
    // which keeps digit 0 visible for an all-zero value.
    always_comb begin
        hi = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (act_en[i] && (act_data[4*i +: 4] != 4'h0)) hi = IW'(i);
        end
    end

    always_comb begin
        phase = (cnt < GAP_END) ? PH_GAP : PH_ON;
        nib   = act_data[{idx, 2'b00} +: 4];
        lit   = act_en[idx] && !(act_lz && (idx > hi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= '1;
        end else if ((phase == PH_ON) && lit) begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= seg_code(nib);
        end else begin
            an  <= '1;
            seg <= '1;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position model with expected-output queue,
// directed scenarios with literal expectations, then randomized loads.
module tb_seg_scan_ctrl;

    localparam int ND = 8;
    localparam int SD = 4;
    localparam int GC = 1;
    localparam int FR = ND * SD;
    localparam int W  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  digit_en = '0;
    logic        lz_en = 1'b0;
    logic        ack;
    logic [7:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // model state: edges since reset, pending and active buffers
    int          m_t;
    logic        m_pv;
    logic [31:0] m_pd, m_ad;
    logic [7:0]  m_pe, m_ae;
    logic        m_pl, m_al;

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GAP_CYC(GC)) dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .digit_en(digit_en),
        .lz_en(lz_en), .ack(ack), .an(an), .seg(seg));

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cond(input string name, input logic cond);
        checks++;
        if (cond !== 1'b1) begin
            errors++;
            $display("FAIL %s actual=0 required=1 an=%h seg=%h at %0t", name, an, seg, $time);
        end
    endtask

    function automatic logic [W-1:0] expect_out(input int pos);
        int d;
        int h;
        d = pos / SD;
        h = 0;
        if ((pos % SD) < GC) return {1'b0, 8'hFF, 7'h7F};
        for (int i = 0; i < ND; i++)
            if (m_ae[i] && (m_ad[4*i +: 4] != 4'h0)) h = i;
        if (!m_ae[d] || (m_al && d > h)) return {1'b0, 8'hFF, 7'h7F};
        return {1'b0, ~(8'(1) << d), seg_tab[m_ad[4*d +: 4]]};
    endfunction

    // model: each edge yields the outputs expected right after it
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_pv = 1'b0;
            m_pd = '0; m_pe = '0; m_pl = 1'b0;
            m_ad = '0; m_ae = '1; m_al = 1'b0;
            exp_q.delete();
        end else begin
            int pos;
            logic [W-1:0] e;
            pos = m_t % FR;
            e = expect_out(pos);
            e[W-1] = (pos == FR-1) && m_pv;
            if (pos == FR-1 && m_pv) begin
                m_ad = m_pd; m_ae = m_pe; m_al = m_pl; m_pv = 1'b0;
            end
            if (load) begin
                m_pd = data; m_pe = digit_en; m_pl = lz_en; m_pv = 1'b1;
            end
            m_t++;
            exp_q.push_back(e);
        end
    end

    // scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            check("reset_hold", {ack, an, seg}, {1'b0, 8'hFF, 7'h7F});
        end else if (exp_q.size() > 0) begin
            check("scoreboard", {ack, an, seg}, exp_q.pop_front());
            check_cond("one_anode", $countones(~an) <= 1);
            check_cond("dark_seg", (an != 8'hFF) || (seg == 7'h7F));
        end
    end

    // driver tasks
    task automatic skip(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] e, input logic lz);
        data = d; digit_en = e; lz_en = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        while (ack !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (ack !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=no_ack required=ack_within_%0d", max);
        end
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", {ack, an, seg}, {1'b0, 8'hFF, 7'h7F});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int guard;
        skip(3);
        rst = 1'b0;
        skip(6);

        // reset mid-slot, then digit 0 shows "0" from the zero active buffer
        mid_reset();
        @(negedge clk);
        check("gap_after_reset", {1'b0, an, seg}, {1'b0, 8'hFF, 7'h7F});
        @(negedge clk);
        check("digit0_after_reset", {1'b0, an, seg}, {1'b0, 8'hFE, 7'b0000001});

        // full value, all digits, no suppression
        do_load(32'h89ABCDEF, 8'hFF, 1'b0);
        wait_ack(2*FR, n);
        @(negedge clk);
        check("ack_one_cycle", {15'd0, ack}, 16'd0);
        @(negedge clk);
        check("digit0_F", {1'b0, an, seg}, {1'b0, 8'hFE, 7'b0111000});
        skip(28);
        check("digit7_8", {1'b0, an, seg}, {1'b0, 8'h7F, 7'b0000000});

        // two loads in one frame, last wins, lz on
        skip(3);
        do_load(32'h11111111, 8'hFF, 1'b1);
        skip(5);
        do_load(32'h00000042, 8'hFF, 1'b1);
        wait_ack(2*FR, n);
        skip(2);
        check("digit0_2", {1'b0, an, seg}, {1'b0, 8'hFE, 7'b0010010});
        skip(4);
        check("digit1_4", {1'b0, an, seg}, {1'b0, 8'hFD, 7'b1001100});
        skip(4);
        check("digit2_dark", {1'b0, an, seg}, {1'b0, 8'hFF, 7'h7F});

        // load exactly on a boundary with nothing pending
        guard = 0;
        while ((m_t % FR) != FR-1 && guard < 2*FR) begin
            @(negedge clk);
            guard++;
        end
        do_load(32'h00001234, 8'hFF, 1'b0);
        check("no_ack_at_boundary", {15'd0, ack}, 16'd0);
        wait_ack(2*FR, n);
        check("ack_next_boundary", 16'(n), 16'd32);

        // zero value with suppression, then digit 0 disabled
        do_load(32'h0, 8'hFF, 1'b1);
        wait_ack(2*FR, n);
        skip(2);
        check("zero_digit0", {1'b0, an, seg}, {1'b0, 8'hFE, 7'b0000001});
        skip(4);
        check("zero_digit1_dark", {1'b0, an, seg}, {1'b0, 8'hFF, 7'h7F});
        do_load(32'h0, 8'hFE, 1'b1);
        wait_ack(2*FR, n);
        for (int k = 0; k < FR; k++) begin
            @(negedge clk);
            check("all_dark_frame", {8'd0, an}, {8'd0, 8'hFF});
        end

        // randomized loads
        repeat (60) begin
            skip($urandom_range(0, 45));
            do_load($urandom >> ($urandom_range(0, 7) * 4), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
        end

        // reset with a pending value discards it
        do_load(32'hCAFE0000, 8'hFF, 1'b0);
        skip(3);
        mid_reset();
        skip(2*FR + 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
